// File: rtl/spwm_pkg.sv
// spwm_pkg: shared constants and FSM state type for the SPWM sine sequencer
package spwm_pkg;
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_FSTEP  = 3'd2;
    localparam logic [2:0] ADDR_AMP    = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam int SIN_MID = 2048;
    localparam int PROD_W  = 44;
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_SCALE, S_MUL, S_UPDATE} state_t;
endpackage

// File: rtl/spwm_sine_rom.sv
// spwm_sine_rom: synchronous sine ROM, s[i] = round(2048 + 2047*sin(2*pi*i/256)), one-cycle read latency
//   i_clk  : clock
//   i_addr : table index (top 8 bits select one of 256 points)
//   o_data : offset-binary sample, registered
module spwm_sine_rom
    import spwm_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_data
);
    // First quadrant of round(2047*sin), points 0..64; the other three are folded from it.
    localparam int Q [65] = '{
           0,   50,  100,  151,  201,  251,  300,  350,  399,  449,
         497,  546,  594,  642,  690,  737,  783,  830,  875,  920,
         965, 1009, 1052, 1095, 1137, 1179, 1219, 1259, 1299, 1337,
        1375, 1411, 1447, 1483, 1517, 1550, 1582, 1614, 1644, 1674,
        1702, 1729, 1756, 1781, 1805, 1828, 1850, 1871, 1891, 1910,
        1927, 1944, 1959, 1973, 1986, 1997, 2008, 2017, 2025, 2032,
        2037, 2041, 2045, 2046, 2047
    };
    logic [7:0]  w_a;
    logic [6:0]  w_j;
    logic [11:0] w_q;
    assign w_a = i_addr[AW-1 -: 8];
    // Second half of each half-wave mirrors the first: index 128-m, taken mod 128.
    assign w_j = w_a[6] ? 7'd0 - w_a[6:0] : w_a[6:0];
    assign w_q = 12'(Q[w_j]);
    always_ff @(posedge i_clk) begin
        o_data <= DW'(w_a[7] ? 12'(SIN_MID) - w_q : 12'(SIN_MID) + w_q);
    end
endmodule

// File: rtl/spwm_sequencer.sv
// spwm_sequencer: Avalon-MM sine-modulation controller loading period/duty into the PWM core each carrier tick
//   csi_clk/csi_reset : clock, synchronous active-high reset
//   avs_*             : register slave (CTRL, PERIOD, FSTEP, AMP, STATUS), registered readdata
//   period_tick       : carrier wrap pulse from the PWM core
//   pwm_en/pwm_t/pwm_d: PWM core enable, period, duty threshold
//   irq               : level interrupt on phase wrap, present only when SPWM_IRQ_EN is defined
module spwm_sequencer
    import spwm_pkg::*;
#(
    parameter int ROM_AW = 8,
    parameter int SIN_W  = 12
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic        avs_chipselect,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        period_tick,
    output logic        pwm_en,
    output logic [31:0] pwm_t,
    output logic [31:0] pwm_d,
    output logic        irq
);
    state_t              r_state;
    logic                r_en, r_ovr;
    logic [31:0]         r_period, r_fstep, r_phase, r_t, r_d, r_rdata;
    logic [15:0]         r_amp;
    logic signed [SIN_W:0] r_scaled;
    logic [PROD_W-1:0]   r_prod;
    logic                w_wr, w_wr_ctrl, w_wr_status, w_clr, w_busy, w_accept, w_overrun;
    logic                w_irq_en, w_irqp;
    logic [31:0]         w_next, w_rdata;
    logic [SIN_W-1:0]    w_sin;
    logic signed [SIN_W:0]    w_delta;
    logic signed [SIN_W+17:0] w_mul;
    logic [SIN_W:0]      w_level;
    logic                w_unused;
    assign w_wr        = avs_chipselect & avs_write;
    assign w_wr_ctrl   = w_wr & (avs_address == ADDR_CTRL);
    assign w_wr_status = w_wr & (avs_address == ADDR_STATUS);
    assign w_clr       = w_wr_ctrl & avs_writedata[1];
    assign w_busy      = r_state != S_IDLE;
    // UPDATE is the last busy cycle; a tick there starts the next sequence back to back.
    assign w_accept    = period_tick & r_en & (r_state == S_IDLE || r_state == S_UPDATE);
    assign w_overrun   = period_tick & r_en & w_busy & (r_state != S_UPDATE);
    assign w_delta     = $signed({1'b0, w_sin}) - $signed((SIN_W+1)'(SIN_MID));
    assign w_mul       = w_delta * $signed({1'b0, r_amp});
    assign w_level     = r_scaled + (SIN_W+1)'(SIN_MID);
    assign w_unused    = ^{w_mul[SIN_W+17], w_level[SIN_W], r_prod[PROD_W-33:0]};
    assign w_rdata = avs_address == ADDR_CTRL   ? {29'd0, w_irq_en, 1'b0, r_en} :
                     avs_address == ADDR_PERIOD ? r_period :
                     avs_address == ADDR_FSTEP  ? r_fstep :
                     avs_address == ADDR_AMP    ? {16'd0, r_amp} :
                     avs_address == ADDR_STATUS ? {29'd0, w_irqp, r_ovr, w_busy} : 32'd0;
    assign avs_readdata = r_rdata;
    assign pwm_en = r_en;
    assign pwm_t  = r_t;
    assign pwm_d  = r_d;
`ifdef SPWM_IRQ_EN
    logic r_irq_en, r_irqp, r_irq, w_carry;
    assign {w_carry, w_next} = {1'b0, r_phase} + {1'b0, r_fstep};
    assign w_irq_en = r_irq_en;
    assign w_irqp   = r_irqp;
    assign irq      = r_irq;
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_irq_en <= 1'b0;
            r_irqp   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= avs_writedata[2];
            // A clear that wins over the add suppresses the wrap; a new wrap beats a W1C.
            r_irqp <= (w_accept & ~w_clr & w_carry) | (r_irqp & ~(w_wr_status & avs_writedata[2]));
            r_irq  <= r_irqp & r_irq_en;
        end
    end
`else
    assign w_next   = r_phase + r_fstep;
    assign w_irq_en = 1'b0;
    assign w_irqp   = 1'b0;
    assign irq      = 1'b0;
`endif
    spwm_sine_rom #(.AW(ROM_AW), .DW(SIN_W)) u_rom (
        .i_clk (csi_clk),
        .i_addr(r_phase[31 -: ROM_AW]),
        .o_data(w_sin)
    );
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_ovr    <= 1'b0;
            r_period <= '0;
            r_fstep  <= '0;
            r_amp    <= '0;
            r_phase  <= '0;
            r_scaled <= '0;
            r_prod   <= '0;
            r_t      <= '0;
            r_d      <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_wr_ctrl) r_en <= avs_writedata[0];
            if (w_wr && avs_address == ADDR_PERIOD) r_period <= avs_writedata;
            if (w_wr && avs_address == ADDR_FSTEP) r_fstep <= avs_writedata;
            if (w_wr && avs_address == ADDR_AMP) r_amp <= avs_writedata[15:0];
            if (avs_chipselect & avs_read) r_rdata <= w_rdata;
            r_phase <= w_clr ? '0 : (w_accept ? w_next : r_phase);
            r_ovr   <= w_overrun | (r_ovr & ~(w_wr_status & avs_writedata[1]));
            if (!r_en) begin
                r_state <= S_IDLE;
                r_d     <= '0;
                r_t     <= r_period;
            end else begin
                case (r_state)
                    S_IDLE:   r_state <= w_accept ? S_LOOKUP : S_IDLE;
                    S_LOOKUP: r_state <= S_SCALE;
                    S_SCALE: begin
                        r_scaled <= w_mul[SIN_W+16:16];
                        r_state  <= S_MUL;
                    end
                    S_MUL: begin
                        r_prod  <= PROD_W'(r_period) * PROD_W'(w_level[SIN_W-1:0]);
                        r_state <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        r_d     <= r_prod[PROD_W-1 -: 32];
                        r_t     <= r_period;
                        r_state <= w_accept ? S_LOOKUP : S_IDLE;
                    end
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spwm_sequencer.sv
// tb_spwm_sequencer: directed stimulus with a behavioural model checked every cycle plus literal expectations
module tb_spwm_sequencer;
    logic        clk = 1'b0, rst = 1'b1, cs = 1'b0, we = 1'b0, rd = 1'b0, ptick = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata, pwm_t, pwm_d;
    logic        pwm_en, irq;
    int          nvec = 0, nerr = 0;
    bit          chk_on = 1'b0;
`ifdef SPWM_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    always #5 clk = ~clk;
    spwm_sequencer dut (
        .csi_clk(clk), .csi_reset(rst), .avs_chipselect(cs), .avs_address(addr),
        .avs_write(we), .avs_writedata(wdata), .avs_read(rd), .avs_readdata(rdata),
        .period_tick(ptick), .pwm_en(pwm_en), .pwm_t(pwm_t), .pwm_d(pwm_d), .irq(irq)
    );
    bit          m_en, m_irqen, m_ov, m_irqp;
    logic [31:0] m_period, m_fstep, m_phase, e_t, e_d, e_rd;
    logic [15:0] m_amp;
    bit          e_irq;
    int          m_age = -1;
    longint      m_s, m_scaled, m_prod;
    function automatic longint sine(input int i);
        return longint'($rtoi(2048.0 + 2047.0 * $sin(2.0 * 3.141592653589793 * i / 256.0) + 0.5));
    endfunction
    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if (n < 0 && q * d != n) q = q - 1;
        return q;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask
    // Model: age counts clocks since an accepted tick; the duty appears four clocks after acceptance.
    initial forever begin
        int a;
        bit acc, ovs, wrt, clr, wrap;
        logic [32:0] sum;
        longint la, lp;
        @(posedge clk);
        if (rst) begin
            m_en = 0; m_irqen = 0; m_ov = 0; m_irqp = 0;
            m_period = 0; m_fstep = 0; m_phase = 0; m_amp = 0;
            e_t = 0; e_d = 0; e_rd = 0; e_irq = 0; m_age = -1;
        end else begin
            a = m_age;
            wrt = cs && we;
            clr = wrt && addr == 3'd0 && wdata[1];
            acc = m_en && ptick && (a < 0 || a == 3);
            ovs = m_en && ptick && a >= 0 && a != 3;
            wrap = 0;
            la = longint'(m_amp);
            lp = longint'(m_period);
            if (cs && rd)
                case (addr)
                    3'd0: e_rd = {29'd0, IRQ & m_irqen, 1'b0, m_en};
                    3'd1: e_rd = m_period;
                    3'd2: e_rd = m_fstep;
                    3'd3: e_rd = {16'd0, m_amp};
                    3'd4: e_rd = {29'd0, IRQ & m_irqp, m_ov, a >= 0};
                    default: e_rd = 32'd0;
                endcase
            e_irq = IRQ & m_irqp & m_irqen;
            if (!m_en) begin
                m_age = -1;
                e_d = 0;
                e_t = m_period;
            end else begin
                if (a == 1) m_scaled = fdiv((m_s - 2048) * la, 65536);
                if (a == 2) m_prod = lp * (2048 + m_scaled);
                if (a == 3) begin
                    e_d = 32'(m_prod / 4096);
                    e_t = m_period;
                end
                m_age = (a >= 0 && a < 3) ? a + 1 : -1;
            end
            sum = {1'b0, m_phase} + {1'b0, m_fstep};
            if (acc) begin
                m_phase = sum[31:0];
                wrap = sum[32] && !clr;
            end
            if (clr) m_phase = 0;
            if (acc) begin
                m_s = sine(int'(m_phase[31:24]));
                m_age = 0;
            end
            m_ov = ovs || (m_ov && !(wrt && addr == 3'd4 && wdata[1]));
            m_irqp = IRQ && (wrap || (m_irqp && !(wrt && addr == 3'd4 && wdata[2])));
            if (wrt)
                case (addr)
                    3'd0: begin m_en = wdata[0]; m_irqen = wdata[2]; end
                    3'd1: m_period = wdata;
                    3'd2: m_fstep = wdata;
                    3'd3: m_amp = wdata[15:0];
                    default: ;
                endcase
        end
    end
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("m_pwm_en", {31'd0, pwm_en}, {31'd0, m_en});
            chk("m_pwm_t", pwm_t, e_t);
            chk("m_pwm_d", pwm_d, e_d);
            chk("m_irq", {31'd0, irq}, {31'd0, e_irq});
            chk("m_readdata", rdata, e_rd);
        end
    end
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1; we = 1; addr = a; wdata = d;
        @(negedge clk);
        cs = 0; we = 0;
    endtask
    task automatic wr_tick(input logic [2:0] a, input logic [31:0] d);
        cs = 1; we = 1; addr = a; wdata = d; ptick = 1;
        @(negedge clk);
        cs = 0; we = 0; ptick = 0;
    endtask
    task automatic tick();
        ptick = 1;
        @(negedge clk);
        ptick = 0;
    endtask
    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        cs = 1; rd = 1; addr = a;
        @(negedge clk);
        cs = 0; rd = 0;
        chk(nm, rdata, exp);
    endtask
    initial begin
        step(2);
        rst = 0;
        chk_on = 1;
        chk("rst_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("rst_pwm_t", pwm_t, 32'd0);
        chk("rst_pwm_d", pwm_d, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_readdata", rdata, 32'd0);
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), 32'd0);
        wr(3'd5, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 3'd5, 32'd0);
        // Mid-scale duty with zero amplitude
        wr(3'd1, 32'd1000);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd1);
        chk("en_after_write", {31'd0, pwm_en}, 32'd1);
        chk("t_follows_period", pwm_t, 32'd1000);
        rd_chk("period_rd", 3'd1, 32'd1000);
        tick();
        rd_chk("status_busy", 3'd4, 32'd1);
        step(2);
        chk("d_before_n4", pwm_d, 32'd0);
        step(1);
        chk("d_amp0", pwm_d, 32'd500);
        chk("t_amp0", pwm_t, 32'd1000);
        rd_chk("status_idle", 3'd4, 32'd0);
        // Full-scale quarter-turn steps
        wr(3'd3, 32'd65535);
        wr(3'd2, 32'h4000_0000);
        wr(3'd0, 32'd5);
        rd_chk("ctrl_rd", 3'd0, IRQ ? 32'd5 : 32'd1);
        tick(); step(9); chk("d_q1", pwm_d, 32'd999);
        tick(); step(9); chk("d_q2", pwm_d, 32'd500);
        tick(); step(9); chk("d_q3", pwm_d, 32'd0);
        tick(); step(9); chk("d_q4", pwm_d, 32'd500);
        chk("irq_wrap", {31'd0, irq}, 32'(IRQ));
        rd_chk("status_wrap", 3'd4, IRQ ? 32'd4 : 32'd0);
        wr(3'd4, 32'd4);
        step(1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        // Overrun: second tick two clocks after the first
        tick(); step(1); tick(); step(2);
        chk("d_overrun_seq", pwm_d, 32'd999);
        step(6);
        chk("d_single_update", pwm_d, 32'd999);
        rd_chk("status_ovr", 3'd4, 32'd2);
        wr(3'd4, 32'd2);
        rd_chk("status_ovr_clr", 3'd4, 32'd0);
        // Back-to-back ticks four clocks apart are both accepted
        tick(); step(3); tick();
        chk("d_b2b_first", pwm_d, 32'd500);
        step(4);
        chk("d_b2b_second", pwm_d, 32'd0);
        rd_chk("status_b2b", 3'd4, 32'd0);
        // Phase clear coinciding with an accepted tick
        wr_tick(3'd0, 32'd7);
        step(4);
        chk("d_clr_tick", pwm_d, 32'd500);
        tick(); step(4);
        chk("d_after_clr", pwm_d, 32'd999);
        // Odd step, amplitude and period; register write coinciding with a tick
        wr(3'd2, 32'h0B00_0000);
        wr(3'd3, 32'd40000);
        wr(3'd1, 32'd777);
        for (int i = 0; i < 6; i++) begin tick(); step(5); end
        wr_tick(3'd1, 32'd1234);
        step(5);
        tick(); step(1); wr(3'd3, 32'd12345); step(6);
        // EN falling mid-sequence
        tick(); step(1); wr(3'd0, 32'd0);
        chk("en_fall_pwm_en", {31'd0, pwm_en}, 32'd0);
        step(1);
        rd_chk("en_fall_busy", 3'd4, 32'd0);
        chk("en_fall_d", pwm_d, 32'd0);
        step(3);
        chk("en_fall_d_hold", pwm_d, 32'd0);
        // Reset mid-sequence
        wr(3'd1, 32'd1000);
        wr(3'd3, 32'd65535);
        wr(3'd2, 32'h4000_0000);
        wr(3'd0, 32'd3);
        tick(); step(4);
        chk("d_pre_reset", pwm_d, 32'd999);
        tick(); step(1);
        rst = 1; step(1); rst = 0;
        chk("rst2_pwm_d", pwm_d, 32'd0);
        chk("rst2_pwm_t", pwm_t, 32'd0);
        chk("rst2_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) rd_chk("rst2_reg", 3'(i), 32'd0);
        tick(); step(6);
        chk("rst2_no_update", pwm_d, 32'd0);
        chk("rst2_en_low", {31'd0, pwm_en}, 32'd0);
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
